// File: rtl/ifetch_ahb.sv
// Instruction fetch initiator: issues word reads to the instruction ROM over an AHB-style
// bus and buffers completed fetches in a small queue consumed by the decoder.
module ifetch_ahb #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] FETCH_LIMIT = 64'd252
) (
    input  logic        HCLK,
    input  logic        HRESET,
    output logic [63:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [63:0] HWDATA,
    input  logic [63:0] HRDATA,
    input  logic        HREADY,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_fault,
    input  logic        inst_ready
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]            q_inst [QUEUE_DEPTH];
    logic [63:0]            q_pc   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_fault;

    logic in_window, has_space, running;
    logic fetch_req, push_fetch, push_fault, push, pop;
    logic unused_bits;

    assign unused_bits = ^{HRDATA[63:32], redirect_pc[1:0]};

    assign in_window  = pc_q < FETCH_LIMIT;
    assign has_space  = cnt_q != CNT_W'(QUEUE_DEPTH);
    assign running    = state_q == RUN;
    assign fetch_req  = running && in_window && has_space;

    // A redirect on the same edge discards both the completing transfer and any pop.
    assign push_fetch = fetch_req && HREADY && !redirect_valid;
    assign push_fault = running && !in_window && has_space && !redirect_valid;
    assign push       = push_fetch || push_fault;
    assign pop        = inst_valid && inst_ready && !redirect_valid;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = {redirect_pc[63:2], 2'b00};
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end else begin
            if (push_fetch) pc_d = pc_q + 64'd4;
            if (push_fault) state_d = HALT;
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Queue storage carries no reset; the head is masked whenever the queue is empty.
    always_ff @(posedge HCLK) begin
        if (push) begin
            q_inst[wr_q]  <= push_fetch ? HRDATA[31:0] : 32'h0;
            q_pc[wr_q]    <= pc_q;
            q_fault[wr_q] <= push_fault;
        end
    end

    assign HADDR      = pc_q;
    assign HTRANS     = (fetch_req && !HRESET) ? 2'b10 : 2'b00;
    assign HWRITE     = 1'b0;
    assign HWDATA     = 64'h0;

    assign inst_valid = cnt_q != '0;
    assign inst       = inst_valid ? q_inst[rd_q]  : 32'h0;
    assign inst_pc    = inst_valid ? q_pc[rd_q]    : 64'h0;
    assign inst_fault = inst_valid ? q_fault[rd_q] : 1'b0;

endmodule

// File: tb/tb_ifetch_ahb.sv
// Bench for ifetch_ahb: combinational ROM responder plus a queue-level reference model
// of the delivered instruction stream and expected bus request.
module tb_ifetch_ahb;

    localparam logic [63:0] LIMIT = 64'd252;
    localparam int          DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [63:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } entry_t;

    entry_t      mq[$];
    logic [63:0] mpc = 64'h0;
    bit          mhalt = 1'b0;
    bit          in_reset = 1'b1;

    ifetch_ahb #(.RESET_PC(64'h0), .QUEUE_DEPTH(DEPTH), .FETCH_LIMIT(LIMIT)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .inst_ready(inst_ready)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign HRDATA = {HADDR[31:0] ^ 32'hDEAD_BEEF, rom_word(HADDR)};

    function automatic logic [163:0] expected();
        entry_t     h;
        logic       v;
        logic [1:0] tr;
        v = mq.size() != 0;
        h = '{inst: 32'h0, pc: 64'h0, fault: 1'b0};
        if (v) h = mq[0];
        tr = (!in_reset && !mhalt && mpc < LIMIT && mq.size() < DEPTH) ? 2'b10 : 2'b00;
        return {v, h.fault, h.inst, h.pc, tr, mpc};
    endfunction

    function automatic logic [163:0] observed();
        return {inst_valid, inst_fault, inst, inst_pc, HTRANS, HADDR};
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc   = 64'h0;
        mhalt = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        entry_t e;
        bit     do_pop;
        bit     space;
        if (!in_reset) begin
            if (redirect_valid) begin
                mq.delete();
                mpc   = {redirect_pc[63:2], 2'b00};
                mhalt = 1'b0;
            end else begin
                do_pop = (mq.size() > 0) && inst_ready;
                space  = mq.size() < DEPTH;
                if (do_pop) e = mq.pop_front();
                if (!mhalt && space) begin
                    if (mpc < LIMIT) begin
                        if (HREADY) begin
                            e = '{inst: rom_word(mpc), pc: mpc, fault: 1'b0};
                            mq.push_back(e);
                            mpc = mpc + 64'd4;
                        end
                    end else begin
                        e = '{inst: 32'h0, pc: mpc, fault: 1'b1};
                        mq.push_back(e);
                        mhalt = 1'b1;
                    end
                end
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge HCLK);
        #1;
        checks++;
        if (observed() !== expected() || HWRITE !== 1'b0 || HWDATA !== 64'h0) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h hwrite=%b hwdata=%h", observed(), expected(), HWRITE, HWDATA);
        end
        HRESET = 1'b0;
        in_reset = 1'b0;
        #1;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 64'h0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_request htrans=%b haddr=%h valid=%b want 10/0/0", HTRANS, HADDR, inst_valid);
        end
        HREADY = 1'b1;
        inst_ready = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst !== rom_word(64'h0) || HADDR !== 64'h4) begin
            failures++;
            $display("FAIL first_latency valid=%b pc=%h inst=%h haddr=%h", inst_valid, inst_pc, inst, HADDR);
        end
    endtask

    task automatic test_stream();
        HREADY = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL stream cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_backpressure();
        HREADY = 1'b1;
        for (int i = 0; i < 18; i++) begin
            inst_ready = (i >= 10);
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL backpressure cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_wait_states();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            HREADY = !(i >= 2 && i < 5);
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL wait_state cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
        HREADY = 1'b1;
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        inst_ready = 1'b0;
        HREADY = 1'b1;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (observed() !== expected() || HADDR !== 64'hC) begin
            failures++;
            $display("FAIL redirect_setup got=%h want=%h", observed(), expected());
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h43;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || HADDR !== 64'h40 || HTRANS !== 2'b10) begin
            failures++;
            $display("FAIL redirect_flush valid=%b haddr=%h htrans=%b want 0/40/10", inst_valid, HADDR, HTRANS);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h40 || inst !== rom_word(64'h40)) begin
            failures++;
            $display("FAIL redirect_first valid=%b pc=%h inst=%h want pc 40", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_fault();
        int seen;
        seen = 0;
        redirect_valid = 1'b1;
        redirect_pc = 64'd236;
        inst_ready = 1'b0;
        HREADY = 1'b1;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            inst_ready = (i >= 6);
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL fault_seq cyc=%0d got=%h want=%h", i, observed(), expected());
            end
            if (inst_valid && inst_fault && inst_ready) begin
                seen++;
                checks++;
                if (inst_pc !== 64'd252 || inst !== 32'h0) begin
                    failures++;
                    $display("FAIL fault_entry pc=%h inst=%h want pc fc inst 0", inst_pc, inst);
                end
            end
        end
        checks++;
        if (seen != 1 || HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL fault_count seen=%0d htrans=%b want 1/00", seen, HTRANS);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 64'h0) begin
            failures++;
            $display("FAIL fault_restart htrans=%b haddr=%h want 10/0", HTRANS, HADDR);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            HREADY = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 4) < 3);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC - 64'($urandom_range(0, 7));
                default: redirect_pc = 64'($urandom_range(0, 319));
            endcase
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1;
        redirect_pc = 64'h20;
        tick();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        HREADY = 1'b1;
        repeat (5) tick();
        HREADY = 1'b0;
        #3;
        HRESET = 1'b1;
        in_reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (inst_valid !== 1'b0 || HTRANS !== 2'b00 || observed() !== expected()) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", observed(), expected());
        end
        @(posedge HCLK);
        #2;
        HRESET = 1'b0;
        in_reset = 1'b0;
        HREADY = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 64'h0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release htrans=%b haddr=%h valid=%b", HTRANS, HADDR, inst_valid);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_wait_states();
        test_redirect();
        test_fault();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
